ps2_host_tx: RTL



---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_sync_edge.sv | 43 ++++
 rtl/ps2_host_tx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, frame constants
// and the odd-parity helper used when latching a command byte.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam int unsigned PS2_DATA_BITS   = 8;
    localparam int unsigned PS2_FRAME_EDGES = 11;

    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 pin with optional falling-edge detect.
// Flops reset to 1 because an idle open-drain PS/2 line floats high.
module ps2_sync_edge #(
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk50Mhz,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic [1:0] sync_q;

    always_ff @(posedge clk50Mhz or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    assign dout = sync_q[1];

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_q;

            always_ff @(posedge clk50Mhz or posedge reset) begin
                if (reset) begin
                    prev_q <= 1'b1;
                end else begin
                    prev_q <= sync_q[1];
                end
            end

            assign fall = prev_q & ~sync_q[1];
        end else begin : g_no_edge
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start, 8 data bits LSB first,
// odd parity, stop, device ACK. Define PS2_TX_RETRY_EN to retry failed frames.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned MAX_RETRIES    = 2
) (
    input  logic                     clk50Mhz,
    input  logic                     reset,
    input  logic [PS2_DATA_BITS-1:0] tx_data,
    input  logic                     send,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    input  logic                     ps2_clk_i,
    input  logic                     ps2_data_i,
    output logic                     ps2_clk_oe,
    output logic                     ps2_data_oe
);

    localparam int unsigned INH_W      = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FRAME_BITS = PS2_DATA_BITS + 1;

    ps2_state_t            state_q, state_d;
    logic [FRAME_BITS-1:0] frame_q;
    logic [3:0]            edge_cnt_q;
    logic [INH_W-1:0]      inh_cnt_q;
    logic [TO_W-1:0]       to_cnt_q;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  clk_oe_q;
    logic                  data_oe_q, data_oe_d;
    logic                  clk_s, clk_fall;
    logic                  data_s, data_fall_unused;
    logic                  accept, in_frame, timeout, fail;

`ifdef PS2_TX_RETRY_EN
    logic [1:0] retry_cnt_q;
    logic       retry_inc;
`else
    // The retry limit is only consumed when retries are built in.
    localparam int unsigned RETRY_LIMIT_UNUSED = MAX_RETRIES;
`endif

    ps2_sync_edge #(.EDGE_EN(1'b1)) u_clk_sync (
        .clk50Mhz (clk50Mhz),
        .reset    (reset),
        .din      (ps2_clk_i),
        .dout     (clk_s),
        .fall     (clk_fall)
    );

    ps2_sync_edge #(.EDGE_EN(1'b0)) u_data_sync (
        .clk50Mhz (clk50Mhz),
        .reset    (reset),
        .din      (ps2_data_i),
        .dout     (data_s),
        .fall     (data_fall_unused)
    );

    assign accept   = (state_q == IDLE) && send;
    assign in_frame = (state_q == SHIFT) || (state_q == ACK) || (state_q == WAIT_IDLE);
    assign timeout  = in_frame && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk50Mhz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_inc = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (send) state_d = INHIBIT;
            end
            INHIBIT: begin
                if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    state_d   = START;
                    data_oe_d = 1'b1;
                end
            end
            START: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                // An edge landing on the expiry cycle is dropped in favour of the timeout.
                if (timeout) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    if (edge_cnt_q < 4'(FRAME_BITS)) begin
                        data_oe_d = ~frame_q[edge_cnt_q];
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end
                end
            end
            ACK: begin
                if (timeout) begin
                    fail = 1'b1;
                end else if (clk_fall && edge_cnt_q == 4'(PS2_FRAME_EDGES - 1)) begin
                    if (data_s) fail = 1'b1;
                    else        state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (timeout) begin
                    fail = 1'b1;
                end else if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fail) begin
            data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_cnt_q < 2'(MAX_RETRIES)) begin
                state_d   = INHIBIT;
                retry_inc = 1'b1;
            end else begin
                state_d = IDLE;
                error_d = 1'b1;
            end
`else
            state_d = IDLE;
            error_d = 1'b1;
`endif
        end

        if (state_d == IDLE) data_oe_d = 1'b0;
    end

    always_ff @(posedge clk50Mhz or posedge reset) begin
        if (reset) begin
            frame_q    <= '0;
            edge_cnt_q <= '0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
        end else begin
            done_q    <= done_d;
            error_q   <= error_d;
            data_oe_q <= data_oe_d;
            clk_oe_q  <= (state_d == INHIBIT) || (state_d == START);
            if (accept) frame_q <= {odd_parity(tx_data), tx_data};
            inh_cnt_q <= (state_q == INHIBIT) ? inh_cnt_q + INH_W'(1) : '0;
            to_cnt_q  <= in_frame ? to_cnt_q + TO_W'(1) : '0;
            if (!((state_q == SHIFT) || (state_q == ACK))) begin
                edge_cnt_q <= '0;
            end else if (clk_fall) begin
                edge_cnt_q <= edge_cnt_q + 4'd1;
            end
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk50Mhz or posedge reset) begin
        if (reset) begin
            retry_cnt_q <= '0;
        end else if (accept) begin
            retry_cnt_q <= '0;
        end else if (retry_inc) begin
            retry_cnt_q <= retry_cnt_q + 2'd1;
        end
    end
`endif

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign error       = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
